// File: rtl/crossbar_pkg.sv
// Shared crossbar defaults and types, used by both the request-side and
// response-side crossbars.
package crossbar_pkg;

    localparam int NUM_INPORT_DEF  = 4;
    localparam int NUM_OUTPORT_DEF = 4;
    localparam int WIDTH_DEF       = 32;

    typedef logic [NUM_INPORT_DEF-1:0] peid_t;
    typedef logic [WIDTH_DEF-1:0]      bank_data_t;

endpackage

// File: rtl/crossbar_out_mux.sv
// Per-PE response mux: picks the lowest bank that owns this PE for a read.
// Ports: owner (banks owning this PE), rd (per-bank read flag),
//        bank_data (per-bank SRAM data), rvalid, rdata (PE response).
module crossbar_out_mux
    import crossbar_pkg::*;
#(
    parameter int NUM_OUTPORT = NUM_OUTPORT_DEF,
    parameter int WIDTH       = WIDTH_DEF
) (
    input  logic [NUM_OUTPORT-1:0]            owner,
    input  logic [NUM_OUTPORT-1:0]            rd,
    input  logic [NUM_OUTPORT-1:0][WIDTH-1:0] bank_data,
    output logic                              rvalid,
    output logic [WIDTH-1:0]                  rdata
);

    always_comb begin
        rvalid = |owner;
        rdata  = '0;
        // Walk downwards so the lowest matching bank wins.
        for (int b = NUM_OUTPORT - 1; b >= 0; b--) begin
            if (owner[b] && rd[b]) begin
                rdata = bank_data[b];
            end
        end
    end

endmodule

// File: rtl/crossbar_out.sv
// Response-side crossbar: routes SRAM bank read data back to the PEs.
// Ports: clk, rst (async high), rden_i/wren_i (per-PE requests),
//        peID_i (per-bank one-hot grant), rdata_i (per-bank data),
//        gnt_o (comb grant), rvalid_o/rdata_o (responses), err_o (sticky).
// Macro CROSSBAR_OUT_REG_EN adds an output register (2-cycle latency).
module crossbar_out
    import crossbar_pkg::*;
#(
    parameter int NUM_INPORT  = NUM_INPORT_DEF,
    parameter int NUM_OUTPORT = NUM_OUTPORT_DEF,
    parameter int WIDTH       = WIDTH_DEF
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_INPORT-1:0]                rden_i,
    input  logic [NUM_INPORT-1:0]                wren_i,
    input  logic [NUM_OUTPORT-1:0][NUM_INPORT-1:0] peID_i,
    input  logic [NUM_OUTPORT-1:0][WIDTH-1:0]    rdata_i,
    output logic [NUM_INPORT-1:0]                gnt_o,
    output logic [NUM_INPORT-1:0]                rvalid_o,
    output logic [NUM_INPORT-1:0][WIDTH-1:0]     rdata_o,
    output logic                                 err_o
);

    logic [NUM_OUTPORT-1:0][NUM_INPORT-1:0] owner_q;
    logic [NUM_OUTPORT-1:0]                 rd_q;
    logic [NUM_OUTPORT-1:0]                 rd_n;
    logic [NUM_INPORT-1:0][NUM_OUTPORT-1:0] owner_t;
    logic [NUM_INPORT-1:0]                  pe_seen;
    logic                                   bank_seen;
    logic                                   err_q;
    logic                                   err_n;
    logic [NUM_INPORT-1:0]                  mux_valid;
    logic [NUM_INPORT-1:0][WIDTH-1:0]       mux_data;

    // Grant OR-reduction, read flags and protocol checks in one pass.
    always_comb begin
        pe_seen   = '0;
        bank_seen = 1'b0;
        rd_n      = '0;
        err_n     = 1'b0;
        for (int b = 0; b < NUM_OUTPORT; b++) begin
            bank_seen = 1'b0;
            for (int p = 0; p < NUM_INPORT; p++) begin
                if (peID_i[b][p]) begin
                    if (bank_seen || pe_seen[p]) begin
                        err_n = 1'b1;
                    end
                    if (rden_i[p] == wren_i[p]) begin
                        err_n = 1'b1;
                    end
                    if (rden_i[p]) begin
                        rd_n[b] = 1'b1;
                    end
                    bank_seen  = 1'b1;
                    pe_seen[p] = 1'b1;
                end
            end
        end
    end

    assign gnt_o = pe_seen;
    assign err_o = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            owner_q <= peID_i;
            rd_q    <= rd_n;
            err_q   <= err_q | err_n;
        end
    end

    // Transpose so each PE mux sees its own column of bank owners.
    always_comb begin
        owner_t = '0;
        for (int p = 0; p < NUM_INPORT; p++) begin
            for (int b = 0; b < NUM_OUTPORT; b++) begin
                owner_t[p][b] = owner_q[b][p];
            end
        end
    end

    for (genvar p = 0; p < NUM_INPORT; p++) begin : g_pe
        crossbar_out_mux #(
            .NUM_OUTPORT (NUM_OUTPORT),
            .WIDTH       (WIDTH)
        ) u_mux (
            .owner     (owner_t[p]),
            .rd        (rd_q),
            .bank_data (rdata_i),
            .rvalid    (mux_valid[p]),
            .rdata     (mux_data[p])
        );
    end

`ifdef CROSSBAR_OUT_REG_EN
    logic [NUM_INPORT-1:0]            rvalid_q;
    logic [NUM_INPORT-1:0][WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= mux_valid;
            rdata_q  <= mux_data;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`else
    assign rvalid_o = mux_valid;
    assign rdata_o  = mux_data;
`endif

endmodule

// File: tb/tb_crossbar_out.sv
// Directed testbench for crossbar_out (both latency configurations).
// Ports of the DUT are driven 1ns after each rising edge and sampled 2ns after.
module tb_crossbar_out;
    import crossbar_pkg::*;

    localparam int NI = NUM_INPORT_DEF;
    localparam int NO = NUM_OUTPORT_DEF;
`ifdef CROSSBAR_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic                clk = 1'b0;
    logic                rst;
    peid_t               rden_i;
    peid_t               wren_i;
    peid_t      [NO-1:0] peID_i;
    bank_data_t [NO-1:0] rdata_i;
    peid_t               gnt_o;
    peid_t               rvalid_o;
    bank_data_t [NI-1:0] rdata_o;
    logic                err_o;

    int passed = 0;
    int total  = 0;

    crossbar_out dut (
        .clk      (clk),
        .rst      (rst),
        .rden_i   (rden_i),
        .wren_i   (wren_i),
        .peID_i   (peID_i),
        .rdata_i  (rdata_i),
        .gnt_o    (gnt_o),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        rden_i  = '0;
        wren_i  = '0;
        peID_i  = '0;
        rdata_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        total++;
        if (rvalid_o !== 4'b0000) $display("FAIL rst_rvalid got %b want 0000", rvalid_o);
        else passed++;
        total++;
        if (rdata_o !== '0) $display("FAIL rst_rdata got %h want 0", rdata_o);
        else passed++;
        total++;
        if (err_o !== 1'b0) $display("FAIL rst_err got %b want 0", err_o);
        else passed++;
        peID_i[1] = 4'b0001;
        wren_i    = 4'b0001;
        #1;
        total++;
        if (gnt_o !== 4'b0001) $display("FAIL rst_gnt got %b want 0001", gnt_o);
        else passed++;
        clear_inputs();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_read();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            clear_inputs();
            if (c == 0) begin
                peID_i[2] = 4'b0010;
                rden_i    = 4'b0010;
            end
            if (c == 1) rdata_i[2] = 32'hDEADBEEF;
            #1;
            if (c == 0) begin
                total++;
                if (gnt_o !== 4'b0010) $display("FAIL read_gnt got %b want 0010", gnt_o);
                else passed++;
            end
            total++;
            if (rvalid_o[1] !== (c == LAT))
                $display("FAIL read_rvalid c%0d got %b want %b", c, rvalid_o[1], c == LAT);
            else passed++;
            total++;
            if (rdata_o[1] !== ((c == LAT) ? 32'hDEADBEEF : 32'h0))
                $display("FAIL read_rdata c%0d got %h", c, rdata_o[1]);
            else passed++;
        end
    endtask

    task automatic test_write();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            clear_inputs();
            if (c == 0) begin
                peID_i[0] = 4'b0001;
                wren_i    = 4'b0001;
            end
            if (c == 1) rdata_i[0] = 32'hFFFFFFFF;
            #1;
            total++;
            if (rvalid_o[0] !== (c == LAT))
                $display("FAIL write_rvalid c%0d got %b want %b", c, rvalid_o[0], c == LAT);
            else passed++;
            total++;
            if (rdata_o[0] !== 32'h0)
                $display("FAIL write_rdata c%0d got %h want 0", c, rdata_o[0]);
            else passed++;
        end
    endtask

    task automatic test_parallel();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            clear_inputs();
            if (c == 0) begin
                for (int b = 0; b < NO; b++) peID_i[b] = peid_t'(1) << (NO - 1 - b);
                rden_i = 4'b1111;
            end
            if (c == 1) begin
                for (int b = 0; b < NO; b++) rdata_i[b] = 32'h1000_0000 + b;
            end
            #1;
            if (c == 0) begin
                total++;
                if (gnt_o !== 4'b1111) $display("FAIL par_gnt got %b want 1111", gnt_o);
                else passed++;
            end
            total++;
            if (rvalid_o !== ((c == LAT) ? 4'b1111 : 4'b0000))
                $display("FAIL par_rvalid c%0d got %b", c, rvalid_o);
            else passed++;
            if (c == LAT) begin
                for (int p = 0; p < NI; p++) begin
                    total++;
                    if (rdata_o[p] !== 32'h1000_0000 + (NO - 1 - p))
                        $display("FAIL par_rdata pe%0d got %h want %h",
                                 p, rdata_o[p], 32'h1000_0000 + (NO - 1 - p));
                    else passed++;
                end
            end
        end
        total++;
        if (err_o !== 1'b0) $display("FAIL par_err got %b want 0", err_o);
        else passed++;
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            clear_inputs();
            if (c == 0) begin
                peID_i[0] = 4'b1000;
                rden_i    = 4'b1000;
            end
            if (c == 1) begin
                peID_i[1]  = 4'b1000;
                rden_i     = 4'b1000;
                rdata_i[0] = 32'hAAAA_0001;
            end
            if (c == 2) rdata_i[1] = 32'hBBBB_0002;
            #1;
            total++;
            if (rvalid_o[3] !== (c == LAT || c == LAT + 1))
                $display("FAIL b2b_rvalid c%0d got %b", c, rvalid_o[3]);
            else passed++;
            total++;
            if (rdata_o[3] !== ((c == LAT) ? 32'hAAAA_0001 :
                                (c == LAT + 1) ? 32'hBBBB_0002 : 32'h0))
                $display("FAIL b2b_rdata c%0d got %h", c, rdata_o[3]);
            else passed++;
        end
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            clear_inputs();
            if (c == 0) begin
                peID_i[2] = 4'b0100;
                rden_i    = 4'b0100;
            end
            if (c == 1) begin
                rst        = 1'b1;
                rdata_i[2] = 32'h5555_5555;
            end
            if (c == 2) begin
                peID_i[0] = 4'b0001;
                wren_i    = 4'b0001;
            end
            if (c == 3) rst = 1'b0;
            #1;
            if (c == 2) begin
                total++;
                if (gnt_o !== 4'b0001) $display("FAIL rif_gnt got %b want 0001", gnt_o);
                else passed++;
            end
            total++;
            if (rvalid_o !== 4'b0000) $display("FAIL rif_rvalid c%0d got %b want 0000", c, rvalid_o);
            else passed++;
            total++;
            if (rdata_o !== '0) $display("FAIL rif_rdata c%0d got %h want 0", c, rdata_o);
            else passed++;
        end
        total++;
        if (err_o !== 1'b0) $display("FAIL rif_err got %b want 0", err_o);
        else passed++;
    endtask

    task automatic test_err_sticky();
        @(posedge clk);
        #1;
        clear_inputs();
        peID_i[3] = 4'b0011;
        rden_i    = 4'b0011;
        #1;
        total++;
        if (err_o !== 1'b0) $display("FAIL sticky_pre got %b want 0", err_o);
        else passed++;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk);
            #1;
            clear_inputs();
            #1;
            total++;
            if (err_o !== 1'b1) $display("FAIL sticky_err c%0d got %b want 1", c, err_o);
            else passed++;
        end
    endtask

    task automatic test_err_cases();
        for (int i = 0; i < 3; i++) begin
            rst = 1'b1;
            clear_inputs();
            #1;
            total++;
            if (err_o !== 1'b0) $display("FAIL errcase%0d_clr got %b want 0", i, err_o);
            else passed++;
            @(posedge clk);
            #1 rst = 1'b0;
            case (i)
                0: begin
                    peID_i[0] = 4'b0001;
                    peID_i[1] = 4'b0001;
                    rden_i    = 4'b0001;
                end
                1: peID_i[1] = 4'b0010;
                default: begin
                    peID_i[1] = 4'b0010;
                    rden_i    = 4'b0010;
                    wren_i    = 4'b0010;
                end
            endcase
            @(posedge clk);
            #1;
            clear_inputs();
            #1;
            total++;
            if (err_o !== 1'b1) $display("FAIL errcase%0d got %b want 1", i, err_o);
            else passed++;
        end
    endtask

    task automatic test_multi_bank();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            clear_inputs();
            if (c == 0) begin
                peID_i[1] = 4'b0001;
                peID_i[3] = 4'b0001;
                rden_i    = 4'b0001;
            end
            if (c == 1) begin
                rdata_i[1] = 32'h1111_1111;
                rdata_i[3] = 32'h3333_3333;
            end
            #1;
            total++;
            if (rvalid_o[0] !== (c == LAT))
                $display("FAIL multi_rvalid c%0d got %b", c, rvalid_o[0]);
            else passed++;
            total++;
            if (rdata_o[0] !== ((c == LAT) ? 32'h1111_1111 : 32'h0))
                $display("FAIL multi_rdata c%0d got %h want lowest bank", c, rdata_o[0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_parallel();
        test_back_to_back();
        test_reset_inflight();
        test_err_sticky();
        test_err_cases();
        test_multi_bank();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
